pipe_drain_fifo: RTL and testbench

Elastic drain buffer sitting directly downstream of the non-stalling data pipeline. The pipeline cannot be back-pressured, so this block absorbs every word it emits into a small first-word-fall-through FIFO and re-presents the data to the consumer with a valid/ready handshake. An `almost_full` early warning, sized for the pipeline's in-flight latency, tells the upstream issuer to stop injecting. Any word that still arrives while the buffer is full is dropped and reported.

---
 rtl/pipe_drain_fifo.sv | 127 ++++++++++++
 tb/tb_pipe_drain_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_drain_fifo.sv
// ----------------------------------------------------------------------------
// pipe_drain_fifo
//
// Elastic drain buffer for a non-stalling data pipeline. Every word the
// pipeline emits is absorbed into a small first-word-fall-through FIFO and
// re-presented to the consumer through a valid/ready handshake. almost_full
// warns the upstream issuer early enough to cover the words still in flight;
// any word arriving while the buffer is full (and not draining) is dropped
// and reported.
//
// Ports
//   clk          in   single clock, rising-edge state updates
//   rst_n        in   asynchronous, active-low reset
//   in_valid     in   qualifier for in_data (pipeline output)
//   in_data      in   WIDTH-bit word from the pipeline
//   out_valid    out  FIFO non-empty; out_data holds the head word
//   out_ready    in   consumer accepts the head word this cycle
//   out_data     out  head-of-FIFO word (unspecified while out_valid = 0)
//   count        out  current occupancy, 0..DEPTH
//   almost_full  out  count >= DEPTH-LAT; upstream must stop injecting
//   overflow     out  sticky: at least one word dropped since reset
//   drop_cnt     out  saturating count of dropped words
// ----------------------------------------------------------------------------
module pipe_drain_fifo #(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LAT   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic full;
    logic pop;
    logic push;
    logic drop;

    // Handshake decode. Everything the consumer sees comes from count_q, so
    // in_valid never reaches out_valid combinationally.
    always_comb begin
        full = (count_q == CW'(DEPTH));
        pop  = (count_q != '0) && out_ready;
        // A pop frees the head slot in the same edge, so a full FIFO that is
        // draining can still take the incoming word.
        push = in_valid && (!full || pop);
        drop = in_valid && full && !pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array carries no reset; stale contents are hidden by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = (count_q >= CW'(DEPTH - LAT));
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// ----------------------------------------------------------------------------
// tb_pipe_drain_fifo
//
// Scoreboard bench for pipe_drain_fifo with default parameters. The stimulus
// process pushes each word it expects the FIFO to accept into exp_q; a
// separate monitor pops and compares whenever the DUT completes a handshake.
// Status outputs are checked directly against hand-computed values.
// ----------------------------------------------------------------------------
module tb_pipe_drain_fifo;

    localparam int unsigned WIDTH = 100;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LAT   = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       count;
    logic             almost_full;
    logic             overflow;
    logic [7:0]       drop_cnt;

    logic [WIDTH-1:0] exp_q [$];
    int unsigned      n_cmp;
    int unsigned      n_bad;

    pipe_drain_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
    endtask

    task automatic drain8();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("drain_count", count, 0);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_sb_empty", exp_q.size(), 0);
    endtask

    // Monitor: a handshake at the next edge is visible at the negedge before it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_pop: got %0h expected none (scoreboard empty)", out_data);
            end else begin
                chk("sb_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        cycle();
        cycle();
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;

        // Fill 1..8 with consumer stalled; almost_full from count 5
        for (int i = 1; i <= 8; i++) begin
            push_exp(WIDTH'(i));
            cycle();
            chk("fill_count", count, i);
            chk("fill_almost_full", almost_full, (i >= 5) ? 1 : 0);
            chk("fill_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        drain8();
        chk("drain_almost_full", almost_full, 0);

        // Streaming 0..39 through the wrap: one-cycle latency, count stays 1
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_exp(WIDTH'(i));
            cycle();
            chk("stream_count", count, 1);
            chk("stream_latency", out_data, i);
            chk("stream_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        cycle();
        chk("stream_end_count", count, 0);
        chk("stream_drops", drop_cnt, 0);

        // Full with simultaneous pop: 0xAA accepted, no drop
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_exp(WIDTH'(8'h10 + i));
            cycle();
        end
        chk("full_count", count, 8);
        push_exp(WIDTH'(8'hAA));
        out_ready = 1'b1;
        cycle();
        chk("fullpop_count", count, 8);
        chk("fullpop_overflow", overflow, 0);
        chk("fullpop_drop_cnt", drop_cnt, 0);
        drain8();

        // Overflow: three words dropped while full and stalled
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_exp(WIDTH'(8'h20 + i));
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(8'hD0 + i);
            cycle();
        end
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop_cnt", drop_cnt, 3);
        drain8();
        chk("ovf_sticky", overflow, 1);

        // Drop saturation: 300 more drops on top of the 3 already counted
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_exp(WIDTH'(8'h30 + i));
            cycle();
        end
        in_valid = 1'b1;
        in_data  = WIDTH'(8'hEE);
        for (int i = 1; i <= 300; i++) begin
            cycle();
            if (i == 251) chk("sat_pre", drop_cnt, 254);
            if (i == 252) chk("sat_hit", drop_cnt, 255);
        end
        chk("sat_hold", drop_cnt, 255);
        chk("sat_count", count, 8);
        drain8();
        chk("sat_after_drain", drop_cnt, 255);

        // Asynchronous reset mid-stream with three words buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(WIDTH'(8'h40 + i));
            cycle();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_almost_full", almost_full, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_drop_cnt", drop_cnt, 0);
        exp_q.delete();
        cycle();
        rst_n = 1'b1;

        // First push after reset release is accepted and visible next cycle
        out_ready = 1'b1;
        push_exp(WIDTH'(100'h5A5A));
        cycle();
        in_valid = 1'b0;
        chk("post_rst_count", count, 1);
        chk("post_rst_data", out_data, 100'h5A5A);
        cycle();
        chk("post_rst_empty", count, 0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
